// File: rtl/ucaspian_axon.sv
// Axon sequencer: queues fired neuron IDs, looks up each neuron's synapse range
// {count, start} in a 256-entry config RAM and issues the range one synapse
// address per handshake to the synapse unit.
module ucaspian_axon #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       clear_config,
    output logic       clear_done,
    output logic       step_done,
    input  logic [7:0] cfg_addr,
    input  logic [7:0] cfg_value,
    input  logic [2:0] cfg_byte,
    input  logic       cfg_enable,
    input  logic [7:0] fire_addr,
    input  logic       fire_vld,
    output logic       fire_rdy,
    output logic [9:0] syn_addr,
    output logic       syn_vld,
    input  logic       syn_rdy
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {AxIdle, AxLookup, AxIssue, AxClear} ax_state_e;

    // Config storage: {count[9:0], start[9:0]} per neuron
    logic [19:0] cfg_ram [256];
    logic [1:0]  start_hi_q;
    logic [1:0]  count_hi_q;
    logic [7:0]  start_lo_q;

    // Fire FIFO
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] fifo_cnt_q;
    logic [CntW-1:0] fifo_cnt_d;
    logic            fire_rdy_q;
    logic            push;
    logic            pop;
    logic            fifo_empty;

    // Sequencer state
    ax_state_e   state_q;
    logic [19:0] rd_data_q;
    logic [9:0]  syn_addr_q;
    logic [9:0]  remaining_q;
    logic        syn_vld_q;
    logic [7:0]  clr_addr_q;
    logic        clear_done_q;
    logic        step_done_q;
    logic        clr_wr;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign push       = fire_vld && fire_rdy_q;
    assign pop        = (state_q == AxIdle) && !fifo_empty && enable && !cfg_enable &&
                        !clear_config;
    // Zeroing sweep runs only while the clear is requested and not yet finished
    assign clr_wr     = !reset && clear_config && (state_q == AxClear) && !clear_done_q;

    // Next FIFO occupancy; flush and reset are applied in the register block
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + CntW'(1);
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - CntW'(1);
        end
    end

    // FIFO pointers, occupancy and the registered ready flag
    always_ff @(posedge clk) begin
        if (reset || clear_config) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            fire_rdy_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            fifo_cnt_q <= fifo_cnt_d;
            fire_rdy_q <= (fifo_cnt_d != CntW'(FIFO_DEPTH));
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push && !clear_config && !reset) begin
            fifo_mem[wr_ptr_q] <= fire_addr;
        end
    end

    // Config byte latches and RAM writes (config bus or clear sweep); survives reset
    always_ff @(posedge clk) begin
        if (cfg_enable && !clear_config) begin
            case (cfg_byte)
                3'd0: begin
                    start_hi_q <= cfg_value[1:0];
                    count_hi_q <= cfg_value[3:2];
                end
                3'd1: start_lo_q <= cfg_value;
                3'd2: cfg_ram[cfg_addr] <= {count_hi_q, cfg_value, start_hi_q, start_lo_q};
                default: ;
            endcase
        end
        if (clr_wr) begin
            cfg_ram[clr_addr_q] <= '0;
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= AxIdle;
            rd_data_q    <= '0;
            syn_addr_q   <= '0;
            remaining_q  <= '0;
            syn_vld_q    <= 1'b0;
            clr_addr_q   <= '0;
            clear_done_q <= 1'b0;
            step_done_q  <= 1'b0;
        end else begin
            if (clear_config) begin
                // Clear wins from any state; an in-flight burst is dropped
                state_q   <= AxClear;
                syn_vld_q <= 1'b0;
                if (state_q != AxClear) begin
                    clr_addr_q   <= '0;
                    clear_done_q <= 1'b0;
                end else if (!clear_done_q) begin
                    clr_addr_q <= clr_addr_q + 8'd1;
                    if (clr_addr_q == 8'd255) begin
                        clear_done_q <= 1'b1;
                    end
                end
            end else begin
                case (state_q)
                    AxIdle: begin
                        if (pop) begin
                            rd_data_q <= cfg_ram[fifo_mem[rd_ptr_q]];
                            state_q   <= AxLookup;
                        end
                    end
                    AxLookup: begin
                        if (rd_data_q[19:10] == 10'd0) begin
                            state_q <= AxIdle;
                        end else begin
                            syn_addr_q  <= rd_data_q[9:0];
                            remaining_q <= rd_data_q[19:10];
                            syn_vld_q   <= 1'b1;
                            state_q     <= AxIssue;
                        end
                    end
                    AxIssue: begin
                        if (syn_vld_q && syn_rdy) begin
                            if (remaining_q == 10'd1) begin
                                syn_vld_q <= 1'b0;
                                state_q   <= AxIdle;
                            end else begin
                                syn_addr_q  <= syn_addr_q + 10'd1;
                                remaining_q <= remaining_q - 10'd1;
                            end
                        end
                    end
                    AxClear: begin
                        state_q      <= AxIdle;
                        clear_done_q <= 1'b0;
                    end
                    default: state_q <= AxIdle;
                endcase
            end
            step_done_q <= (state_q == AxIdle) && fifo_empty && !syn_vld_q && !fire_vld &&
                           !clear_config;
        end
    end

    assign fire_rdy   = fire_rdy_q;
    assign syn_addr   = syn_addr_q;
    assign syn_vld    = syn_vld_q;
    assign clear_done = clear_done_q;
    assign step_done  = step_done_q;

endmodule

// File: tb/tb_ucaspian_axon.sv
// Bench for ucaspian_axon: expected synapse addresses are queued when a fire is
// accepted and a monitor pops/compares them on every handshake.
module tb_ucaspian_axon;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       clear_config;
    logic       clear_done;
    logic       step_done;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_value;
    logic [2:0] cfg_byte;
    logic       cfg_enable;
    logic [7:0] fire_addr;
    logic       fire_vld;
    logic       fire_rdy;
    logic [9:0] syn_addr;
    logic       syn_vld;
    logic       syn_rdy;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random

    logic [9:0]  exp_q [$];
    logic [19:0] model_ram [256];

    always #5 clk = ~clk;

    ucaspian_axon #(.FIFO_DEPTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .clear_config(clear_config),
        .clear_done  (clear_done),
        .step_done   (step_done),
        .cfg_addr    (cfg_addr),
        .cfg_value   (cfg_value),
        .cfg_byte    (cfg_byte),
        .cfg_enable  (cfg_enable),
        .fire_addr   (fire_addr),
        .fire_vld    (fire_vld),
        .fire_rdy    (fire_rdy),
        .syn_addr    (syn_addr),
        .syn_vld     (syn_vld),
        .syn_rdy     (syn_rdy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Program one neuron's range through the byte-wide config bus
    task automatic cfg(input logic [7:0] id, input logic [9:0] start, input logic [9:0] count);
        cfg_enable = 1'b1;
        cfg_addr   = id;
        cfg_byte   = 3'd0;
        cfg_value  = {4'b0, count[9:8], start[9:8]};
        step();
        cfg_byte  = 3'd1;
        cfg_value = start[7:0];
        step();
        cfg_byte  = 3'd2;
        cfg_value = count[7:0];
        step();
        cfg_enable = 1'b0;
        cfg_byte   = 3'd5;
        model_ram[id] = {count, start};
    endtask

    // Offer one fire; on acceptance the model's burst is appended to the scoreboard
    task automatic fire(input logic [7:0] id);
        int left = 300;
        logic [9:0] st;
        logic [9:0] cnt;
        while (!fire_rdy && left > 0) begin
            step();
            left--;
        end
        if (!fire_rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL fire_rdy_timeout: got fire_rdy=0 required 1 for id %0d", id);
        end else begin
            {cnt, st} = model_ram[id];
            for (int i = 0; i < int'(cnt); i++) begin
                exp_q.push_back(st + 10'(i));
            end
            fire_vld  = 1'b1;
            fire_addr = id;
            step();
            fire_vld = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int left = budget;
        while (!(exp_q.size() == 0 && step_done && !syn_vld) && left > 0) begin
            step();
            left--;
        end
        n_tests++;
        if (!(exp_q.size() == 0 && step_done && !syn_vld)) begin
            n_fail++;
            $display("FAIL idle_timeout: got %0d addresses outstanding, step_done=%0b; required 0, 1",
                     exp_q.size(), step_done);
        end
    endtask

    task automatic wait_vld(input int budget);
        int left = budget;
        while (!syn_vld && left > 0) begin
            step();
            left--;
        end
        check("syn_vld_seen", syn_vld, 1);
    endtask

    // Clear sweep: raised before edge T, done must show from just after edge T+256
    task automatic do_clear();
        clear_config = 1'b1;
        step();
        check("clear_syn_vld", syn_vld, 0);
        check("clear_fire_rdy", fire_rdy, 0);
        exp_q.delete();
        for (int k = 1; k <= 256; k++) begin
            step();
            if (k == 255) check("clear_done_early", clear_done, 0);
        end
        check("clear_done_set", clear_done, 1);
        step();
        step();
        check("clear_done_held", clear_done, 1);
        clear_config = 1'b0;
        step();
        check("clear_done_drop", clear_done, 0);
        for (int i = 0; i < 256; i++) model_ram[i] = '0;
    endtask

    // Synapse-side ready generator
    initial begin
        syn_rdy = 1'b1;
        forever begin
            step();
            case (rdy_mode)
                0:       syn_rdy = 1'b1;
                1:       syn_rdy = ~syn_rdy;
                default: syn_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compare every handshake with the scoreboard, and check stall stability
    initial begin
        logic       prev_stall = 1'b0;
        logic [9:0] prev_addr  = '0;
        logic [9:0] exp_addr;
        forever begin
            @(negedge clk);
            if (syn_vld && prev_stall) check("syn_addr_hold", syn_addr, prev_addr);
            if (syn_vld && syn_rdy) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_syn: got syn_addr=%0d, required no request", syn_addr);
                end else begin
                    exp_addr = exp_q.pop_front();
                    check("syn_addr", syn_addr, exp_addr);
                end
            end
            prev_stall = syn_vld && !syn_rdy;
            prev_addr  = syn_addr;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        enable       = 1'b1;
        clear_config = 1'b0;
        cfg_addr     = '0;
        cfg_value    = '0;
        cfg_byte     = '0;
        cfg_enable   = 1'b0;
        fire_addr    = '0;
        fire_vld     = 1'b0;
        step();
        step();
        check("rst_syn_vld", syn_vld, 0);
        check("rst_syn_addr", syn_addr, 0);
        check("rst_fire_rdy", fire_rdy, 0);
        check("rst_step_done", step_done, 0);
        check("rst_clear_done", clear_done, 0);
        reset = 1'b0;
        step();
        check("fire_rdy_after_rst", fire_rdy, 1);

        // Initial clear also zeroes the RAM contents
        do_clear();

        // Single burst with latency check
        cfg(8'd5, 10'd100, 10'd3);
        fire(8'd5);
        check("lat_T", syn_vld, 0);
        step();
        check("lat_T1", syn_vld, 0);
        step();
        check("lat_T2_vld", syn_vld, 1);
        check("lat_T2_addr", syn_addr, 100);
        wait_idle(100);
        check("single_step_done", step_done, 1);

        // Wrap and backpressure
        rdy_mode = 1;
        cfg(8'd9, 10'd1022, 10'd4);
        fire(8'd9);
        wait_idle(200);
        rdy_mode = 0;

        // Zero-count neuron issues nothing and goes straight back to idle
        cfg(8'd7, 10'd50, 10'd0);
        fire(8'd7);
        check("zero_vld_T", syn_vld, 0);
        step();
        check("zero_vld_T1", syn_vld, 0);
        step();
        check("zero_step_done_T2", step_done, 0);
        step();
        check("zero_step_done_T3", step_done, 1);
        check("zero_vld_T3", syn_vld, 0);

        // FIFO full with enable low, then drain in push order
        enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cfg(8'(10 + i), 10'($urandom_range(0, 1023)), 10'($urandom_range(1, 3)));
        end
        for (int i = 0; i < 16; i++) begin
            fire(8'(10 + i));
            check("full_fire_rdy", fire_rdy, (i < 15) ? 1 : 0);
        end
        fire_vld  = 1'b1;
        fire_addr = 8'd10;
        step();
        step();
        check("full_no_push", fire_rdy, 0);
        fire_vld = 1'b0;
        rdy_mode = 2;
        enable   = 1'b1;
        step();
        check("full_rdy_after_pop", fire_rdy, 1);
        wait_idle(2000);

        // Randomized fires over a small neuron table
        for (int i = 0; i < 8; i++) begin
            cfg(8'(30 + i), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 5)));
        end
        for (int n = 0; n < 30; n++) begin
            rdy_mode = $urandom_range(0, 2);
            fire(8'(30 + $urandom_range(0, 7)));
            repeat ($urandom_range(0, 3)) step();
        end
        wait_idle(3000);
        rdy_mode = 0;

        // Clear mid-burst: burst abandoned, config gone afterwards
        cfg(8'd40, 10'd200, 10'd20);
        fire(8'd40);
        wait_vld(20);
        step();
        step();
        do_clear();
        fire(8'd5);
        fire(8'd40);
        for (int i = 0; i < 8; i++) begin
            step();
            check("post_clear_no_vld", syn_vld, 0);
        end
        wait_idle(100);

        // Reset mid-burst: outputs reset, config survives
        rdy_mode = 2;
        cfg(8'd41, 10'd500, 10'd10);
        fire(8'd41);
        wait_vld(20);
        step();
        step();
        reset = 1'b1;
        step();
        check("mid_rst_syn_vld", syn_vld, 0);
        check("mid_rst_syn_addr", syn_addr, 0);
        check("mid_rst_fire_rdy", fire_rdy, 0);
        check("mid_rst_step_done", step_done, 0);
        check("mid_rst_clear_done", clear_done, 0);
        exp_q.delete();
        reset = 1'b0;
        step();
        check("post_rst_fire_rdy", fire_rdy, 1);
        fire(8'd41);
        wait_idle(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ucaspian_axon.md
# ucaspian_axon

Axon sequencer that turns neuron fire events into per-synapse fire requests for one `ucaspian_synapse` unit. Fired neuron IDs are queued in a small FIFO. For each ID the block looks up the neuron's contiguous synapse range, given as a start address and a count, in a 256-entry axon configuration RAM. It then walks that range, issuing one synapse address per handshake on the synapse's `syn_addr`/`syn_vld`/`syn_rdy` port. It sits between the neuron/fire logic and the synapse unit, and shares the unit's configuration bus and clear/step-done conventions.

## Interface
- `FIFO_DEPTH`, default 16, fire FIFO entries; must be a power of two, at least 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; clears FIFO, FSM and outputs; does not clear the config RAM.
- `enable`  in  1  allows new fires to be popped from the FIFO.
- `clear_config`  in  1  level; zeroes the config RAM and flushes the FIFO.
- `clear_done`  out  1  high once the clear has finished; held while `clear_config` stays high.
- `step_done`  out  1  high when the block is quiescent.
- `cfg_addr`  in  8  neuron ID being configured.
- `cfg_value`  in  8  config byte.
- `cfg_byte`  in  3  byte select.
- `cfg_enable`  in  1  config write strobe; also blocks new pops.
- `fire_addr`  in  8  fired neuron ID.
- `fire_vld`  in  1  fire request.
- `fire_rdy`  out  1  FIFO can accept a fire.
- `syn_addr`  out  10  synapse address to fire.
- `syn_vld`  out  1  `syn_addr` is valid.
- `syn_rdy`  in  1  synapse unit accepts.

## Operation
- **Config RAM:** 256 x 20 bits, holding `{count[9:0], start[9:0]}`. Only the active `cfg_byte` codes below apply while `cfg_enable` is high and `clear_config` is low.
  - `cfg_byte` 0: latch `start_hi = cfg_value[1:0]` and `count_hi = cfg_value[3:2]`.
  - `cfg_byte` 1: latch `start_lo`.
  - `cfg_byte` 2: write `{count_hi, cfg_value, start_hi, start_lo}` to `ram[cfg_addr]`.
  - Other `cfg_byte` codes are ignored.
- **Fire FIFO:**
  - A push happens when `fire_vld && fire_rdy`.
  - `fire_rdy` is a registered output equal to `!full && !clear_config && !reset`.
  - A simultaneous push and pop leaves the occupancy unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **FSM states:** `AX_IDLE`, `AX_LOOKUP`, `AX_ISSUE`, `AX_CLEAR`.
- **`AX_IDLE`:**
  - If FIFO is non-empty and `enable && !cfg_enable`: pop, issue the RAM read at the popped ID, go to `AX_LOOKUP`.
  - `clear_config` goes to `AX_CLEAR`.
- **`AX_LOOKUP`:** register the RAM data.
  - If count == 0: return to `AX_IDLE` with no synapse issued.
  - Otherwise: set `syn_addr = start`, `remaining = count`, `syn_vld = 1`, go to `AX_ISSUE`.
- **`AX_ISSUE`:** on `syn_vld && syn_rdy`:
  - If remaining == 1: `syn_vld <= 0`, go to `AX_IDLE`.
  - Otherwise: `syn_addr <= syn_addr + 1` (10-bit, 1023 wraps to 0) and decrement `remaining`.
  - While `syn_vld && !syn_rdy`, `syn_addr` is held stable.
  - A burst in progress always completes, even if `enable` drops or `cfg_enable` rises.
- **`AX_CLEAR`:**
  - Entered from any state on `clear_config`.
  - `syn_vld` drops immediately and any in-flight burst is abandoned.
  - The FIFO is flushed.
  - Writes zero to RAM addresses 0..255, one per cycle.
  - After address 255, `clear_done <= 1`.
  - Stays in `AX_CLEAR` until `clear_config` falls, then goes to `AX_IDLE` with `clear_done <= 0`.
- **`step_done`** is registered and high when all of the following hold: state `AX_IDLE`, FIFO empty, `!syn_vld`, `!fire_vld`.

## Timing
- **Reset values:** `syn_vld` 0, `syn_addr` 0, `fire_rdy` 0, `step_done` 0, `clear_done` 0. FIFO is empty and state is `AX_IDLE`. Reset overrides everything, including a clear in progress.
- **Fire-to-issue latency:** a fire accepted at edge T produces `syn_vld` high in cycle T+3 (the pop is at edge T+1, `AX_LOOKUP` runs in cycle T+2). The FIFO is assumed idle beforehand and `enable` high.
- **Throughput:** one synapse address per cycle while `syn_rdy` is held high.
- **Back-to-back fires:** the first address of the next burst appears 2 cycles after the last handshake of the previous burst.
- **Full FIFO:** `fire_rdy` is low in the cycle after the push that fills it, and returns high one cycle after a pop.
- **Clear:** with `clear_config` raised at edge T, `clear_done` is high from cycle T+257.

## Test plan
- **Single burst:** neuron 5 configured with start=100, count=3; fire 5 with `syn_rdy` tied high. Expected: `syn_addr` 100, 101, 102 on consecutive cycles; `syn_vld` first high 3 cycles after the fire; `step_done` returns high afterwards.
- **Wrap and backpressure:** start=1022, count=4; `syn_rdy` toggling every other cycle. Expected: addresses 1022, 1023, 0, 1, each held stable until its handshake.
- **FIFO full:** `enable` low; 16 fires pushed. Expected: `fire_rdy` low after the 16th push. Raise `enable`: all 16 bursts are issued in push order.
- **Zero count:** neuron 7 has count=0; fire 7. Expected: no `syn_vld`; the FSM is back in `AX_IDLE` 2 cycles after the pop.
- **Clear during a burst:** raise `clear_config` mid-burst. Expected: `syn_vld` drops the next cycle; `clear_done` high 257 cycles after the raise. A later fire to any previously configured neuron issues nothing.
- **Reset mid-burst:** assert `reset` mid-burst. Expected: all outputs at reset values the next cycle. Config entries survive, so a re-fire reproduces the original addresses.
